uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Outbound UART transmitter: serializes processed sample bytes (filter/FFT results) onto the serial line to the host.
- It is the transmit-direction counterpart of the inbound sample path.
- Upstream logic hands it one byte at a time over a valid/ready handshake. The block emits start, data (LSB first), optional parity, and stop bits at a fixed baud set by a clock divider.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range >= 2
DATA_BITS, 8, data bits per frame; legal 5..8
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; legal 1 or 2

Ports:
clk  input  1  system clock; all logic is on its rising edge
rst  input  1  asynchronous, active-low reset
in_data  input  DATA_BITS  byte to transmit; sampled on the accept cycle only
in_valid  input  1  upstream has a byte
in_ready  output  1  block can accept; high only in IDLE
tx  output  1  serial line, idle high, registered
busy  output  1  high from the cycle after accept until the frame ends
done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-low.
- Reset (rst = 0, asynchronous): state = IDLE, tx = 1, in_ready = 1, busy = 0, done = 0. Baud counter, bit index and shift register are cleared.
- Reset asserted mid-frame aborts the frame immediately: tx goes to 1 without waiting for a clock edge. No done pulse is produced.
- Accept: occurs at a rising edge with state = IDLE and in_valid = 1.
  - in_data is latched into the shift register.
  - The parity bit is computed from in_data and latched: even = XOR of data bits; odd = its inverse.
  - State moves to START. tx = 0 from the following cycle.
- States and transitions:
  - IDLE -> START on accept.
  - START lasts CLKS_PER_BIT cycles -> DATA.
  - DATA lasts DATA_BITS x CLKS_PER_BIT cycles. tx = shift[0]; shift right at the end of each bit period. -> PARITY if PARITY_MODE != 0, else -> STOP.
  - PARITY lasts CLKS_PER_BIT cycles; tx = latched parity bit -> STOP.
  - STOP lasts STOP_BITS x CLKS_PER_BIT cycles with tx = 1 -> IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps at the end of each bit period.
  - Width is clog2(CLKS_PER_BIT).
  - Reloads to 0 on every state change.
- Frame length: (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) x CLKS_PER_BIT cycles, measured from the first tx = 0 cycle.
- done: asserted on the last cycle of the final stop bit. On that same edge the state returns to IDLE, so in_ready = 1 on the next cycle.
- Back-to-back frames: if in_valid is held high, the next accept occurs on the first IDLE cycle. The next start bit therefore follows the stop bit with exactly one idle-high cycle between frames.
- in_data changing while busy has no effect.
- in_valid deasserting at any time other than the accept cycle has no effect.
- Illegal parameter values are caught by an elaboration-time check.

Decomposition:
- Shared package (uart_pkg) holds:
  - state enum: IDLE, START, DATA, PARITY, STOP;
  - PARITY_NONE / PARITY_ODD / PARITY_EVEN constants;
  - a clog2-width helper for the baud counter.
- One natural sub-module: uart_baud_tick. It is a CLKS_PER_BIT divider with a synchronous restart input and a one-cycle tick output at the end of each bit. It is reused by the receive path.
- FSM, shift register and parity are kept in the top module.

Test Plan:
- CLKS_PER_BIT = 4, 8N1; send 0xA5 -> tx sequence per 4-cycle bit is 0, 1,0,1,0,0,1,0,1, 1. busy is high for 40 cycles. done pulses once on cycle 40. in_ready returns high on cycle 41.
- Same config; in_valid held high with 0x00 then 0xFF -> two frames separated by exactly one idle-high cycle. Data bits are all 0, then all 1. Two done pulses.
- PARITY_MODE = 2 (even), send 0x07 -> parity bit = 1. PARITY_MODE = 1 (odd), send 0x07 -> parity bit = 0. Frame is 44 cycles.
- STOP_BITS = 2, DATA_BITS = 5, send 0x1F -> the stop high period lasts 8 cycles. Total frame is 32 cycles.
- Assert rst low at cycle 15 of a frame -> tx = 1 and in_ready = 1 asynchronously. No done pulse. After release, sending 0x3C yields a clean full frame.
- in_data toggled randomly while busy -> the transmitted bits equal the byte latched at accept.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART serial path.
//   state_t        : transmitter FSM states (IDLE, START, DATA, PARITY, STOP)
//   PARITY_*       : parity mode encodings for the PARITY_MODE parameter
//   BIT_IDX_W      : width of the data/stop bit index (covers up to 8 bits)
//   cnt_width()    : baud counter width for a given CLKS_PER_BIT
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int BIT_IDX_W = 3;

  // clog2 of the divider, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider shared by the transmit and receive paths.
// Counts 0..CLKS_PER_BIT-1 and wraps; tick is high during the last cycle of
// each bit period.
//   clk     : system clock
//   rst     : asynchronous active-low reset (counter cleared)
//   restart : synchronous reload of the counter to 0
//   tick    : one-cycle pulse on the final cycle of a bit period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int              CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes one byte per handshake as
// start(0), data LSB first, optional parity, stop(1) bits.
//   clk      : system clock
//   rst      : asynchronous active-low reset; aborts any frame, tx forced high
//   in_data  : byte to send, sampled only on the accept cycle
//   in_valid : upstream has a byte
//   in_ready : high only in IDLE
//   tx       : registered serial line, idle high
//   busy     : high while a frame is on the line
//   done     : one-cycle pulse on the last cycle of the final stop bit
//
// Handshake: a transfer (accept) happens on a rising edge where
// in_valid && in_ready. in_ready does not depend on in_valid; in_valid may
// drop at any time without effect outside the accept cycle.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
      $error("uart_tx_serializer: DATA_BITS must be 5..8");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
      $error("uart_tx_serializer: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam logic [BIT_IDX_W-1:0] LAST_DATA = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_STOP = BIT_IDX_W'(STOP_BITS - 1);

  state_t                 state, state_next;
  logic [DATA_BITS-1:0]   shift, shift_next;
  logic [BIT_IDX_W-1:0]   bit_idx, bit_next;
  logic                   par, par_next;
  logic                   tx_next;
  logic                   tick;
  logic                   restart;

  // Counter held at 0 while idle and reloaded on every state change, so each
  // state's first bit period is a full CLKS_PER_BIT long.
  assign restart = (state == IDLE) || (state_next != state);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_next = state;
    shift_next = shift;
    bit_next   = bit_idx;
    par_next   = par;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = START;
          shift_next = in_data;
          bit_next   = '0;
          par_next   = (PARITY_MODE == PARITY_ODD) ? ~(^in_data) : (^in_data);
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = shift >> 1;
          if (bit_idx == LAST_DATA) begin
            state_next = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          bit_next   = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_idx == LAST_STOP) begin
            state_next = IDLE;
            done       = 1'b1;
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // tx is registered from the next-state view so the line changes on the
  // same edge as the state.
  always_comb begin
    tx_next = 1'b1;
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_idx <= bit_next;
      par     <= par_next;
      tx      <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       valid  [4];
  logic       tx_w   [4];
  logic       rdy_w  [4];
  logic       busy_w [4];
  logic       done_w [4];

  int pass_cnt;
  int total_cnt;

  // Instances: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 5N2; all CLKS_PER_BIT = 4.
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid[0]),
    .in_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid[1]),
    .in_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid[2]),
    .in_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(2)) u_5n2 (
    .clk(clk), .rst(rst), .in_data(in_data[4:0]), .in_valid(valid[3]),
    .in_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Driver: present a byte to one instance for a single accept edge.
  task automatic send(input int idx, input logic [7:0] d);
    @(negedge clk);
    check("ready_before_send", 32'(rdy_w[idx]), 32'd1);
    in_data    = d;
    valid[idx] = 1'b1;
    @(posedge clk);
    #1;
    valid[idx] = 1'b0;
  endtask

  // Scoreboard: build the expected bit sequence, then check every cycle of
  // the frame starting just after the accept edge.
  task automatic expect_frame(input int idx, input logic [7:0] d, input int nd,
                              input int pm, input int ns, input bit scramble);
    logic exp_q[$];
    logic p;
    int   len;
    exp_q.delete();
    exp_q.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < nd; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pm != 0) exp_q.push_back((pm == 1) ? ~p : p);
    for (int i = 0; i < ns; i++) exp_q.push_back(1'b1);
    len = exp_q.size() * CPB;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (scramble) in_data = 8'($urandom_range(0, 255));
      check($sformatf("tx[%0d]_c%0d", idx, c), 32'(tx_w[idx]), 32'(exp_q[c / CPB]));
      check($sformatf("busy[%0d]_c%0d", idx, c), 32'(busy_w[idx]), 32'd1);
      check($sformatf("ready[%0d]_c%0d", idx, c), 32'(rdy_w[idx]), 32'd0);
      check($sformatf("done[%0d]_c%0d", idx, c), 32'(done_w[idx]), (c == len - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic expect_idle(input int idx, input string tag);
    @(negedge clk);
    check({tag, "_tx"},    32'(tx_w[idx]),   32'd1);
    check({tag, "_ready"}, 32'(rdy_w[idx]),  32'd1);
    check({tag, "_busy"},  32'(busy_w[idx]), 32'd0);
    check({tag, "_done"},  32'(done_w[idx]), 32'd0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    in_data   = 8'h00;
    for (int i = 0; i < 4; i++) valid[i] = 1'b0;
    rst = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i),    32'(tx_w[i]),   32'd1);
      check($sformatf("rst_ready%0d", i), 32'(rdy_w[i]),  32'd1);
      check($sformatf("rst_busy%0d", i),  32'(busy_w[i]), 32'd0);
      check($sformatf("rst_done%0d", i),  32'(done_w[i]), 32'd0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, 0xA5: 40-cycle frame, ready again on cycle 41
    send(0, 8'hA5);
    expect_frame(0, 8'hA5, 8, 0, 1, 1'b0);
    expect_idle(0, "a5_after");

    // Back-to-back with in_valid held: 0x00 then 0xFF, one idle cycle between
    @(negedge clk);
    in_data  = 8'h00;
    valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_data = 8'hFF;
    expect_frame(0, 8'h00, 8, 0, 1, 1'b0);
    @(negedge clk);
    check("b2b_gap_tx",    32'(tx_w[0]),  32'd1);
    check("b2b_gap_ready", 32'(rdy_w[0]), 32'd1);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    expect_frame(0, 8'hFF, 8, 0, 1, 1'b0);
    expect_idle(0, "b2b_after");

    // Even parity 0x07 -> parity 1; odd parity 0x07 -> parity 0; 44 cycles
    send(1, 8'h07);
    expect_frame(1, 8'h07, 8, 2, 1, 1'b0);
    expect_idle(1, "even_after");
    send(2, 8'h07);
    expect_frame(2, 8'h07, 8, 1, 1, 1'b0);
    expect_idle(2, "odd_after");

    // 5N2, 0x1F: 8-cycle stop period, 32-cycle frame
    send(3, 8'h1F);
    expect_frame(3, 8'h1F, 5, 0, 2, 1'b0);
    expect_idle(3, "5n2_after");

    // Reset at cycle 15 of a frame: immediate abort, no done
    send(0, 8'h00);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check($sformatf("abort_pre_done_c%0d", c), 32'(done_w[0]), 32'd0);
    end
    check("abort_pre_tx", 32'(tx_w[0]), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("abort_async_tx",    32'(tx_w[0]),   32'd1);
    check("abort_async_ready", 32'(rdy_w[0]),  32'd1);
    check("abort_async_busy",  32'(busy_w[0]), 32'd0);
    check("abort_async_done",  32'(done_w[0]), 32'd0);
    @(negedge clk);
    check("abort_hold_done", 32'(done_w[0]), 32'd0);
    rst = 1'b1;
    expect_idle(0, "abort_release");

    // Clean frame after reset, with in_data scrambled while busy
    send(0, 8'h3C);
    expect_frame(0, 8'h3C, 8, 0, 1, 1'b1);
    expect_idle(0, "3c_after");
    send(0, 8'h96);
    expect_frame(0, 8'h96, 8, 0, 1, 1'b1);
    expect_idle(0, "96_after");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
